// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
// Groups the fetch-control bundle between the pipeline control logic and the
// PC sequencer.
//   master : the pipeline side. It drives the stall, multiply/divide and
//            redirect requests and observes the fetch address and status.
//   slave  : the sequencer side. It receives the requests and drives
//            pc, pc_plus1, fetch_valid, flush and md_busy.
interface pc_sequencer_if;
  logic        stall;
  logic        md_start;
  logic        md_rdy;
  logic        br_taken;
  logic [11:0] br_base;
  logic [11:0] br_offset;
  logic        jmp;
  logic [11:0] jmp_target;
  logic [11:0] pc;
  logic [11:0] pc_plus1;
  logic        fetch_valid;
  logic        flush;
  logic        md_busy;

  modport master (
    output stall, md_start, md_rdy, br_taken, br_base, br_offset, jmp, jmp_target,
    input  pc, pc_plus1, fetch_valid, flush, md_busy
  );

  modport slave (
    input  stall, md_start, md_rdy, br_taken, br_base, br_offset, jmp, jmp_target,
    output pc, pc_plus1, fetch_valid, flush, md_busy
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Program-counter controller for the 12-bit fetch path. It owns the PC
// register and selects between the following next-PC sources:
//   - sequential advance
//   - branch redirect
//   - jump redirect
//   - hazard stall
//   - a multi-cycle multiply/divide wait
// Ports:
//   clock : rising-edge system clock
//   reset : synchronous, active-low reset
//   bus   : pc_sequencer_if.slave, which carries these signals:
//           stall, md_start, md_rdy, br_taken, br_base, br_offset, jmp,
//           jmp_target (inputs)
//           pc, fetch_valid, flush, md_busy (registered outputs)
//           pc_plus1 (combinational from pc)
module pc_sequencer #(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic         clock,
  input  logic         reset,
  pc_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    MD_WAIT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [11:0] pc_q, pc_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic        flush_q, flush_d;
  logic        md_busy_q, md_busy_d;

  logic [11:0] pc_plus1;
  logic [11:0] br_target;

  // All PC arithmetic is 12-bit and drops the carry-out, so the wrap from
  // FFF to 000 is automatic. A negative offset works through the same wrap.
  assign pc_plus1  = pc_q + 12'd1;
  assign br_target = bus.br_base + 12'd1 + bus.br_offset;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_valid_d = fetch_valid_q;
    flush_d       = 1'b0;
    md_busy_d     = md_busy_q;

    case (state_q)
      BOOT: begin
        state_d       = RUN;
        fetch_valid_d = 1'b1;
        md_busy_d     = 1'b0;
      end

      RUN: begin
        fetch_valid_d = 1'b1;
        // A redirect outranks md_start, so md_start is dropped in that case.
        // A stall also masks md_start, because decode re-issues it.
        if (bus.jmp) begin
          pc_d    = bus.jmp_target;
          flush_d = 1'b1;
        end else if (bus.br_taken) begin
          pc_d    = br_target;
          flush_d = 1'b1;
        end else if (bus.stall) begin
          pc_d = pc_q;
        end else if (bus.md_start) begin
          state_d       = MD_WAIT;
          md_busy_d     = 1'b1;
          fetch_valid_d = 1'b0;
        end else begin
          pc_d = pc_plus1;
        end
      end

      MD_WAIT: begin
        fetch_valid_d = 1'b0;
        // The PC stays held on the exit cycle. Advancing resumes only once
        // the state is back in RUN.
        if (bus.md_rdy) begin
          state_d       = RUN;
          md_busy_d     = 1'b0;
          fetch_valid_d = 1'b1;
        end
      end

      default: begin
        state_d       = BOOT;
        fetch_valid_d = 1'b0;
        md_busy_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      fetch_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      md_busy_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_valid_q <= fetch_valid_d;
      flush_q       <= flush_d;
      md_busy_q     <= md_busy_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.pc_plus1    = pc_plus1;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.flush       = flush_q;
  assign bus.md_busy     = md_busy_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic clock;
  logic reset;
  int   n_chk;
  int   n_pass;

  pc_sequencer_if bus ();

  pc_sequencer #(.RESET_PC(12'h000)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", tag, got, exp);
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clr_in();
    bus.stall      = 1'b0;
    bus.md_start   = 1'b0;
    bus.md_rdy     = 1'b0;
    bus.br_taken   = 1'b0;
    bus.br_base    = 12'h000;
    bus.br_offset  = 12'h000;
    bus.jmp        = 1'b0;
    bus.jmp_target = 12'h000;
  endtask

  task automatic chk_state(input string tag, input logic [11:0] pc,
                           input logic fv, input logic fl, input logic mb);
    check({tag, ".pc"},    {20'd0, bus.pc},          {20'd0, pc});
    check({tag, ".fv"},    {31'd0, bus.fetch_valid}, {31'd0, fv});
    check({tag, ".flush"}, {31'd0, bus.flush},       {31'd0, fl});
    check({tag, ".busy"},  {31'd0, bus.md_busy},     {31'd0, mb});
  endtask

  task automatic do_jmp(input logic [11:0] tgt);
    bus.jmp        = 1'b1;
    bus.jmp_target = tgt;
    step();
    bus.jmp        = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    clr_in();
    reset = 1'b0;
    step();
    step();
    chk_state("rst", 12'h000, 1'b0, 1'b0, 1'b0);

    // Release reset. The first edge goes BOOT->RUN and pc=000 becomes valid.
    reset = 1'b1;
    step();
    chk_state("boot", 12'h000, 1'b1, 1'b0, 1'b0);
    step(); chk_state("run1", 12'h001, 1'b1, 1'b0, 1'b0);
    step(); chk_state("run2", 12'h002, 1'b1, 1'b0, 1'b0);
    step(); chk_state("run3", 12'h003, 1'b1, 1'b0, 1'b0);
    check("pc_plus1", {20'd0, bus.pc_plus1}, 32'h004);

    // Wrap: jump to FFD, then run FFE, FFF, 000.
    do_jmp(12'hFFD);
    chk_state("wrap.j", 12'hFFD, 1'b1, 1'b1, 1'b0);
    step(); chk_state("wrap0", 12'hFFE, 1'b1, 1'b0, 1'b0);
    step(); chk_state("wrap1", 12'hFFF, 1'b1, 1'b0, 1'b0);
    check("wrap.plus1", {20'd0, bus.pc_plus1}, 32'h000);
    step(); chk_state("wrap2", 12'h000, 1'b1, 1'b0, 1'b0);

    // Branch at pc=010: 00C + 1 + FFC = 009.
    do_jmp(12'h010);
    bus.br_taken  = 1'b1;
    bus.br_base   = 12'h00C;
    bus.br_offset = 12'hFFC;
    step();
    chk_state("br", 12'h009, 1'b1, 1'b1, 1'b0);
    clr_in();
    step(); chk_state("br.next", 12'h00A, 1'b1, 1'b0, 1'b0);

    // Priority: jmp, br_taken and md_start together at pc=020.
    do_jmp(12'h020);
    bus.jmp        = 1'b1;
    bus.jmp_target = 12'h0A5;
    bus.br_taken   = 1'b1;
    bus.br_base    = 12'h100;
    bus.br_offset  = 12'h010;
    bus.md_start   = 1'b1;
    step();
    chk_state("prio", 12'h0A5, 1'b1, 1'b1, 1'b0);
    clr_in();
    step(); chk_state("prio.run", 12'h0A6, 1'b1, 1'b0, 1'b0);

    // A stall together with md_start holds pc and ignores md_start.
    bus.stall    = 1'b1;
    bus.md_start = 1'b1;
    step(); chk_state("stall", 12'h0A6, 1'b1, 1'b0, 1'b0);
    clr_in();
    step(); chk_state("stall.rel", 12'h0A7, 1'b1, 1'b0, 1'b0);

    // Multiply wait at pc=030, with redirect and stall noise while waiting.
    do_jmp(12'h030);
    bus.md_start = 1'b1;
    step();
    chk_state("md.enter", 12'h030, 1'b0, 1'b0, 1'b1);
    bus.md_start   = 1'b0;
    bus.br_taken   = 1'b1;
    bus.br_base    = 12'h200;
    bus.jmp        = 1'b1;
    bus.jmp_target = 12'h300;
    bus.stall      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_state($sformatf("md.wait%0d", i), 12'h030, 1'b0, 1'b0, 1'b1);
    end
    bus.md_rdy = 1'b1;
    step();
    chk_state("md.rdy", 12'h030, 1'b1, 1'b0, 1'b0);
    clr_in();
    step(); chk_state("md.resume", 12'h031, 1'b1, 1'b0, 1'b0);

    // Reset during MD_WAIT.
    bus.md_start = 1'b1;
    step();
    chk_state("md2.enter", 12'h031, 1'b0, 1'b0, 1'b1);
    bus.md_start = 1'b0;
    reset = 1'b0;
    step();
    chk_state("md2.rst", 12'h000, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    step(); chk_state("md2.boot", 12'h000, 1'b1, 1'b0, 1'b0);
    step(); chk_state("md2.run", 12'h001, 1'b1, 1'b0, 1'b0);

    // Reset on the same edge as a jump: the pending flush is cancelled.
    bus.jmp        = 1'b1;
    bus.jmp_target = 12'h555;
    reset = 1'b0;
    step();
    chk_state("rstjmp", 12'h000, 1'b0, 1'b0, 1'b0);
    clr_in();
    reset = 1'b1;
    step(); chk_state("rstjmp.boot", 12'h000, 1'b1, 1'b0, 1'b0);

    // md_rdy while in RUN has no effect.
    bus.md_rdy = 1'b1;
    step(); chk_state("rdy.run", 12'h001, 1'b1, 1'b0, 1'b0);
    clr_in();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter controller for the 12-bit fetch path of the full processor. It owns the PC register and uses the 12-bit +1 incrementer to advance it each cycle. It selects between sequential advance, branch redirect, jump redirect, hazard stall and a multi-cycle multiply/divide wait. Its outputs drive the instruction-memory address, the fetch-stage valid bit and the pipeline flush line.

## Interface
- RESET_PC, 12'h000, PC value loaded on reset
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clock
- stall  in  1  data-hazard stall from decode; hold PC
- md_start  in  1  multiply/divide issued this cycle
- md_rdy  in  1  multiply/divide result ready
- br_taken  in  1  conditional branch resolved taken
- br_base  in  12  PC of the branch instruction
- br_offset  in  12  two's-complement branch offset
- jmp  in  1  unconditional jump (j/jal/jr) resolved
- jmp_target  in  12  absolute jump target
- pc  out  12  current fetch address (registered)
- pc_plus1  out  12  pc + 1 via 12-bit incrementer (combinational from pc)
- fetch_valid  out  1  fetch at pc is valid this cycle (registered)
- flush  out  1  one-cycle pulse: squash younger instructions (registered)
- md_busy  out  1  high while in MD_WAIT (registered)

## Operation
- States: BOOT, RUN, MD_WAIT. State encoding is implementation-chosen.
- Reset (reset==0 at an edge): state=BOOT, pc=RESET_PC, fetch_valid=0, flush=0, md_busy=0.
- BOOT: pc holds; fetch_valid=0. Next cycle: RUN with fetch_valid=1. Ignores all other inputs.
- RUN next-PC priority, highest first:
  - jmp: pc←jmp_target, flush=1.
  - br_taken: pc←br_base+1+br_offset, mod 4096, flush=1.
  - stall: pc holds, flush=0.
  - md_start: pc holds, state→MD_WAIT, md_busy=1.
  - otherwise: pc←pc_plus1.
- A redirect with md_start in the same cycle: redirect wins, md_start is dropped, and state stays RUN.
- stall with md_start in the same cycle: md_start is ignored, because decode re-issues it.
- MD_WAIT:
  - pc holds; fetch_valid=0; jmp, br_taken and stall are ignored.
  - When md_rdy=1: state→RUN and md_busy=0 next cycle; pc is still held that cycle, and advancing resumes the cycle after.
- Arithmetic:
  - All PC math is 12-bit unsigned and wraps: 12'hFFF+1=12'h000.
  - Branch target ignores carry-out.
  - br_offset is added as its 12-bit pattern, so sign is handled by wrap.
- flush is high only in the cycle after a redirect is accepted; otherwise 0.

## Timing
- pc, fetch_valid, flush, md_busy and state update on the rising clock edge. pc_plus1 settles combinationally from pc within the cycle.
- Redirect latency: jmp or br_taken sampled at edge N; the new pc is visible after edge N, and flush=1 for the cycle N→N+1.
- Sequential throughput: one PC per cycle in RUN with no stall.
- Reset release: the first edge with reset==1 moves BOOT→RUN. pc=RESET_PC is first fetched with fetch_valid=1 in the cycle after that edge.
- Reset mid-operation (any state, including MD_WAIT): the full reset values apply at that edge, and a pending flush is cancelled.
- md_rdy in RUN and md_start in MD_WAIT have no effect.

## Test plan
- Reset then 5 free-run cycles: fetch_valid=0 for one cycle, then pc = 000, 001, 002, 003 with flush=0 throughout.
- Wrap: force pc to FFE, run 3 cycles: pc = FFE, FFF, 000, with no flag changes.
- Branch: at pc=010 assert br_taken with br_base=00C and br_offset=FFC (−4). Required: pc=009 next cycle, flush=1 for exactly one cycle, then pc=00A.
- Priority: assert jmp (jmp_target=0A5), br_taken and md_start together at pc=020. Required: pc=0A5, flush=1, state RUN, md_busy=0.
- Multiply wait: at pc=030 assert md_start, then hold md_rdy=0 for 4 cycles with br_taken=1 noise. Required: pc=030 and md_busy=1 throughout. Then pulse md_rdy: md_busy=0 next cycle, and pc=031 the cycle after.
- Reset during MD_WAIT: reset=0 for one edge. Required: pc=RESET_PC, md_busy=0, flush=0, fetch_valid=0; the next cycle is BOOT behaviour.
